// File: rtl/line_buf_pkg.sv
// Shared definitions for the line read-out path: FSM encodings, address
// layout and the pixel-word field positions.
package line_buf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int LINE_STRIDE_LOG2 = 10;
    localparam int RADR_W           = 2 + 10 + LINE_STRIDE_LOG2;

    localparam int PIX_R_LSB = 0;
    localparam int PIX_G_LSB = 8;
    localparam int PIX_B_LSB = 16;
    localparam int PIX_W     = 8;

    // Word address of a burst: page, line, then word offset within the line.
    function automatic logic [RADR_W-1:0] burst_addr(
        input logic [1:0]                  vram,
        input logic [9:0]                  line,
        input logic [LINE_STRIDE_LOG2-1:0] word_idx
    );
        return {vram, line, word_idx};
    endfunction

endpackage

// File: rtl/line_rd_req_fsm.sv
// Burst request sequencer: walks one display line in BURST_LEN-word bursts,
// one burst outstanding at a time, and counts the returned words.
module line_rd_req_fsm
    import line_buf_pkg::*;
#(
    parameter int LINE_WORDS = 640,
    parameter int BURST_LEN  = 16,
    parameter int ADR_W      = 22
) (
    input  logic             FCLK_CLK0,
    input  logic             stop_n_rstb,
    input  logic             start,
    input  logic [9:0]       start_line,
    input  logic [1:0]       start_vram,
    input  logic             u_rack,
    input  logic             u_rd_da_en,
    output logic             in_idle,
    output logic             in_data,
    output logic             active_nxt,
    output logic             word_acc,
    output logic             line_end,
    output logic             u_rreq,
    output logic [ADR_W-1:0] u_radr
);

    localparam int              CNT_W      = $clog2(BURST_LEN);
    localparam logic [9:0]      LAST_BURST = 10'(LINE_WORDS / BURST_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [9:0]       burst_idx_q, burst_idx_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [9:0]       line_l_q, line_l_d;
    logic [1:0]       vram_l_q, vram_l_d;
    logic             rreq_q, rreq_d;
    logic [LINE_STRIDE_LOG2-1:0] word_idx_s;
    logic             burst_last_s;

    assign word_idx_s   = LINE_STRIDE_LOG2'(burst_idx_q * BURST_LEN);
    assign burst_last_s = (word_cnt_q == LAST_WORD);

    // Next-state, counter and line-latch logic.
    always_comb begin
        state_d     = state_q;
        burst_idx_d = burst_idx_q;
        word_cnt_d  = word_cnt_q;
        line_l_d    = line_l_q;
        vram_l_d    = vram_l_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    line_l_d    = start_line;
                    vram_l_d    = start_vram;
                    burst_idx_d = 10'd0;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (u_rack) begin
                    word_cnt_d = '0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                if (u_rd_da_en && burst_last_s) begin
                    word_cnt_d = '0;
                    if (burst_idx_q == LAST_BURST) begin
                        state_d = ST_DONE;
                    end else begin
                        burst_idx_d = burst_idx_q + 10'd1;
                        state_d     = ST_REQ;
                    end
                end else if (u_rd_da_en) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rreq_d = (state_d == ST_REQ);
    end

    // State and counter registers.
    always_ff @(posedge FCLK_CLK0 or negedge stop_n_rstb) begin
        if (!stop_n_rstb) begin
            state_q     <= ST_IDLE;
            burst_idx_q <= 10'd0;
            word_cnt_q  <= '0;
            line_l_q    <= 10'd0;
            vram_l_q    <= 2'd0;
            rreq_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_idx_q <= burst_idx_d;
            word_cnt_q  <= word_cnt_d;
            line_l_q    <= line_l_d;
            vram_l_q    <= vram_l_d;
            rreq_q      <= rreq_d;
        end
    end

    assign in_idle    = (state_q == ST_IDLE);
    assign in_data    = (state_q == ST_DATA);
    assign active_nxt = (state_d != ST_IDLE);
    assign word_acc   = in_data && u_rd_da_en;
    assign line_end   = (state_d == ST_DONE);
    assign u_rreq     = rreq_q;
    assign u_radr     = ADR_W'(burst_addr(vram_l_q, line_l_q, word_idx_s));

endmodule

// File: rtl/line_buf_out.sv
// Fetches one display line per request from VRAM and streams it to the
// video-out block; a single shadow slot queues the latest request while busy.
module line_buf_out
    import line_buf_pkg::*;
#(
    parameter int LINE_WORDS = 640,
    parameter int BURST_LEN  = 16,
    parameter int ADR_W      = 22
) (
    input  logic             FCLK_CLK0,
    input  logic             stop_n_rstb,
    input  logic             line_req,
    input  logic [11:0]      line_no,
    input  logic [1:0]       vram_no,
    output logic [31:0]      line_data,
    output logic             line_data_en,
    output logic             line_busy,
    output logic             line_done,
    output logic             u_rreq,
    input  logic             u_rack,
    output logic [ADR_W-1:0] u_radr,
    input  logic [31:0]      u_rd_da,
    input  logic             u_rd_da_en,
    output logic             ovf_err
);

    logic        in_idle_s, in_data_s, active_nxt_s, word_acc_s, line_end_s;
    logic        start_s;
    logic [9:0]  start_line_s;
    logic [1:0]  start_vram_s;
    logic        unused_line_hi_s;

    logic        pending_q, pending_d;
    logic [9:0]  shadow_line_q, shadow_line_d;
    logic [1:0]  shadow_vram_q, shadow_vram_d;
    logic [31:0] line_data_q, line_data_d;
    logic        line_data_en_q, line_data_en_d;
    logic        line_done_q, line_done_d;
    logic        line_busy_q, line_busy_d;
    logic        ovf_q, ovf_d;

    assign unused_line_hi_s = &{1'b0, line_no[11:10]};

    // A request arriving in IDLE beats the shadow copy: latest request wins.
    assign start_s      = line_req || pending_q;
    assign start_line_s = line_req ? line_no[9:0] : shadow_line_q;
    assign start_vram_s = line_req ? vram_no : shadow_vram_q;

    line_rd_req_fsm #(
        .LINE_WORDS (LINE_WORDS),
        .BURST_LEN  (BURST_LEN),
        .ADR_W      (ADR_W)
    ) u_fsm (
        .FCLK_CLK0   (FCLK_CLK0),
        .stop_n_rstb (stop_n_rstb),
        .start       (start_s),
        .start_line  (start_line_s),
        .start_vram  (start_vram_s),
        .u_rack      (u_rack),
        .u_rd_da_en  (u_rd_da_en),
        .in_idle     (in_idle_s),
        .in_data     (in_data_s),
        .active_nxt  (active_nxt_s),
        .word_acc    (word_acc_s),
        .line_end    (line_end_s),
        .u_rreq      (u_rreq),
        .u_radr      (u_radr)
    );

    // Pending shadow, output pipeline and sticky overflow flag.
    always_comb begin
        pending_d     = pending_q;
        shadow_line_d = shadow_line_q;
        shadow_vram_d = shadow_vram_q;
        if (line_req && !in_idle_s) begin
            pending_d     = 1'b1;
            shadow_line_d = line_no[9:0];
            shadow_vram_d = vram_no;
        end else if (in_idle_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        line_data_d    = word_acc_s ? u_rd_da : line_data_q;
        line_data_en_d = word_acc_s;
        line_done_d    = line_end_s;
        line_busy_d    = active_nxt_s || pending_d;
        ovf_d          = ovf_q || (u_rd_da_en && !in_data_s);
    end

    // Output and bookkeeping registers.
    always_ff @(posedge FCLK_CLK0 or negedge stop_n_rstb) begin
        if (!stop_n_rstb) begin
            pending_q      <= 1'b0;
            shadow_line_q  <= 10'd0;
            shadow_vram_q  <= 2'd0;
            line_data_q    <= 32'd0;
            line_data_en_q <= 1'b0;
            line_done_q    <= 1'b0;
            line_busy_q    <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            shadow_line_q  <= shadow_line_d;
            shadow_vram_q  <= shadow_vram_d;
            line_data_q    <= line_data_d;
            line_data_en_q <= line_data_en_d;
            line_done_q    <= line_done_d;
            line_busy_q    <= line_busy_d;
            ovf_q          <= ovf_d;
        end
    end

    assign line_data    = line_data_q;
    assign line_data_en = line_data_en_q;
    assign line_done    = line_done_q;
    assign line_busy    = line_busy_q;
    assign ovf_err      = ovf_q;

endmodule

// File: doc/line_buf_out.md
Name: line_buf_out

Overview:
- Read-side counterpart of the DDR line writer.
- On a line request from the 480p video-out block, issues burst read requests on the u_r* memory port of mem_if_sys and fetches one full display line from the selected VRAM page.
- Streams the returned words to the video-out block as line_data/line_data_en.
- Sits between mem_if_sys and v480p_24b_out, entirely in the FCLK_CLK0 domain.

Parameters:
- LINE_WORDS, 640: 32-bit words (pixels) per line; must be a multiple of BURST_LEN.
- BURST_LEN, 16: words returned per accepted read request.
- ADR_W, 22: width of u_radr (word address).

Ports:
- FCLK_CLK0 in 1: system clock; all logic is synchronous to its rising edge.
- stop_n_rstb in 1: reset, asynchronous, active-low; clock FCLK_CLK0.
- line_req in 1: one-cycle pulse, synchronous to FCLK_CLK0; requests a line.
- line_no in 12: line index; sampled when line_req is accepted; bits [9:0] used.
- vram_no in 2: VRAM page; sampled with line_no.
- line_data out 32: pixel word, {8'h00, B[7:0], G[7:0], R[7:0]} as stored.
- line_data_en out 1: line_data valid qualifier.
- line_busy out 1: high while a line fetch is in progress or pending.
- line_done out 1: one-cycle pulse after the last word of a line is output.
- u_rreq out 1: memory read request.
- u_rack in 1: one-cycle acknowledge of u_rreq.
- u_radr out ADR_W: word address of the burst.
- u_rd_da in 32: read data from memory.
- u_rd_da_en in 1: read data valid.
- ovf_err out 1: sticky error flag.

Behaviour:
- Reset values: every output 0; FSM in IDLE; pending flag 0; all counters 0.
- Address: u_radr = {vram_no_l, line_no_l[9:0], word_idx[9:0]}, where word_idx = burst_idx*BURST_LEN. Line stride is 1024 words.
- FSM states:
  - IDLE: on line_req (or pending set), latch line_no/vram_no, clear burst_idx, clear pending, go to REQ. line_busy = 1 from the next cycle.
  - REQ: u_rreq = 1 with u_radr stable. On u_rack, drop u_rreq the next cycle, clear word_cnt, go to DATA. u_rreq stays high indefinitely with no u_rack; there is no timeout.
  - DATA: each u_rd_da_en registers u_rd_da to line_data and pulses line_data_en one cycle later (fixed 1-cycle latency, no reordering, gaps allowed). When word_cnt reaches BURST_LEN-1 with u_rd_da_en: if burst_idx == LINE_WORDS/BURST_LEN-1, go to DONE; otherwise increment burst_idx and go to REQ.
  - DONE: one cycle. line_done pulses coincident with the final line_data_en. Go to IDLE; line_busy drops the following cycle unless pending is set.
- Only one burst is outstanding at a time. A new u_rreq is never issued before all BURST_LEN words of the previous burst have arrived.
- line_req while busy:
  - Sets pending and latches the new line_no/vram_no into a one-deep shadow register; the current line continues untouched.
  - A second line_req while pending overwrites the shadow (latest wins).
  - IDLE with pending starts the shadow line without a gap cycle.
- line_req in the same cycle as DONE is treated as pending and serviced next.
- u_rd_da_en outside DATA (IDLE/REQ/DONE):
  - The word is dropped and line_data_en stays 0.
  - ovf_err is set and stays set until reset.
- u_rack outside REQ is ignored.
- Counters: word_cnt is log2(BURST_LEN) bits; burst_idx is 10 bits. Both are cleared on entry to REQ/IDLE as stated, and there is no wrap inside a line.
- Reset mid-operation: asynchronous clear of everything; an in-flight burst's remaining data is not tracked. Upstream holds reset until mem_if_sys is quiescent.

Decomposition:
- Shared package line_buf_pkg:
  - state enum {IDLE, REQ, DATA, DONE};
  - LINE_STRIDE_LOG2 = 10;
  - pixel-word field positions R/G/B.
- Sub-module: line_rd_req_fsm (FSM, address generation, burst/word counters). The top holds the output register, pending shadow and error flag.

Test Plan:
- Single line: line_req with line_no=5, vram_no=1, memory returns an incrementing pattern → 40 requests at u_radr = 0x101400 + 16k (k = 0..39); 640 line_data_en with data equal to the pattern, in order; one line_done on word 640.
- Ack delay: u_rack returned 50 cycles after u_rreq → u_radr stable and u_rreq held all 50 cycles; no line_data_en before data arrives.
- Back-to-back: line_req(line 7) during line 6, then line_req(line 8) before line 6 ends → line 6 completes, then line 8 only (line 7 discarded); no idle gap between lines.
- Gapped data: u_rd_da_en toggling every other cycle → output mirrors input with exactly 1-cycle latency; word count still 640.
- Stray data: u_rd_da_en asserted in IDLE → ovf_err = 1 and stays 1; line_data_en stays 0; the next line fetches normally.
- Reset mid-burst: stop_n_rstb low during burst 3 → all outputs 0 immediately; after release, line_req starts at burst_idx 0.
